apb2axi: RTL and testbench
==========================

// Module: apb2axi
// PURPOSE
//  APB slave to AXI master bridge: the reverse of the AXI-to-APB bridge. Each APB
//  transfer from a peripheral-side master (debug unit, DMA config port) becomes one
//  single-beat 32-bit AXI transaction on the system interconnect. One transfer
//  outstanding at a time; the APB access is stalled via pready until the AXI
//  response returns.
// PARAMETERS
//  AXI_ID_WIDTH   6            width of AWID/BID/ARID/RID
//  AXI_ADDR_WIDTH 32           AXI address width
//  AXI_DATA_WIDTH 64           AXI data width; power of 2, >= 32
//  APB_ADDR_WIDTH 12           APB address width; <= AXI_ADDR_WIDTH
//  AXI_BASE_ADDR  32'h1A10_0000 OR'd onto zero-extended paddr to form AXI address
//  AXI_ID         0            constant ID driven on AWID/ARID
// PORTS
//  clk      in  1   clock, rising edge
//  rstn     in  1   asynchronous active-low reset
//  psel     in  1   APB select          | penable in 1 APB enable | pwrite in 1 APB write
//  paddr    in  APB_ADDR_WIDTH  APB byte address
//  pwdata   in  32  APB write data
//  prdata   out 32  APB read data       | pready out 1 | pslverr out 1
//  AWID/AWADDR/AWLEN[7:0]/AWSIZE[2:0]/AWVALID out, AWREADY in   AXI write address
//  WDATA/WSTRB(AXI_DATA_WIDTH/8)/WLAST/WVALID out, WREADY in    AXI write data
//  BID in ID, BRESP in 2, BVALID in, BREADY out                 AXI write response
//  ARID/ARADDR/ARLEN/ARSIZE/ARVALID out, ARREADY in             AXI read address
//  RID in ID, RDATA in AXI_DATA_WIDTH, RRESP in 2, RLAST in, RVALID in, RREADY out
// BEHAVIOUR
//  Reset: state IDLE; all *VALID, BREADY, RREADY, pready, pslverr = 0; prdata = 0.
//  FSM: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
//  IDLE: on psel & !penable (setup phase) register paddr, pwdata, pwrite;
//   next state WR_REQ if pwrite else RD_REQ. psel & penable in IDLE is ignored.
//  Address: {AXI_BASE_ADDR | paddr} with bits[1:0] forced 0. AxLEN=0, AxSIZE=3'b010,
//   WLAST=1, AxID=AXI_ID. lane = addr[2 +: log2(AXI_DATA_WIDTH/32)] (0 when width 32).
//  WR_REQ: AWVALID and WVALID raised together on entry; each dropped independently
//   after its own handshake; AW/W payloads stable while valid. Exit to WR_RESP in the
//   cycle after the later handshake (same cycle handshakes -> one WR_REQ cycle).
//   WDATA = pwdata replicated to all lanes; WSTRB = 4'hF << (4*lane).
//  WR_RESP: BREADY=1; on BVALID capture BRESP -> DONE.
//  RD_REQ: ARVALID=1 until ARREADY -> RD_RESP.
//  RD_RESP: RREADY=1; on RVALID capture RDATA[32*lane +: 32] into prdata and RRESP -> DONE.
//  DONE: one cycle. pready = 1 and pslverr = resp[1] (SLVERR/DECERR -> 1, OKAY/EXOKAY
//   -> 0), both registered outputs. Always returns to IDLE.
//  pready = 0 in every other state; prdata holds its last read value (writes do not
//   change it).
//  BID/RID and RLAST not checked; single outstanding transaction.
//  Minimum latency, setup to pready: 4 cycles with zero-wait AXI slave.
//  APB master dropping psel mid-transfer is a protocol violation. The AXI
//   transaction still completes and DONE is still visited, so no AXI transaction is
//   ever abandoned except by reset.
//  Reset mid-transaction: immediate return to IDLE, valids drop (system reset only).
// TESTING
//  1 Write paddr=0x004, pwdata=0xDEADBEEF, AXI 64b zero-wait -> AWADDR=0x1A100004,
//    WSTRB=8'hF0, WDATA=0xDEADBEEF_DEADBEEF, BRESP=OKAY -> pready 4 cycles after
//    setup, pslverr=0.
//  2 Read paddr=0x008, RDATA=0x11111111_22222222 -> ARADDR=0x1A100008,
//    prdata=0x22222222, pready asserted for one cycle.
//  3 Write with AWREADY after 3 cycles, WREADY immediately -> WVALID drops after 1
//    cycle, AWVALID held 3, BREADY only after both handshakes.
//  4 Read with RRESP=2'b10 -> pslverr=1 with pready; next write with OKAY ->
//    pslverr=0.
//  5 Back-to-back APB transfers (setup right after DONE) -> each accepted, no lost
//    or duplicated AXI transaction.
//  6 Assert rstn low in WR_RESP -> all outputs at reset values; next transfer
//    completes normally.

Source files
------------

// File: rtl/apb2axi.sv
// apb2axi: APB slave to AXI master bridge, one single-beat 32-bit AXI transaction per APB transfer.
// The APB access stalls on pready until the AXI response returns; only one transfer is in flight.
module apb2axi #(
  parameter int                        AXI_ID_WIDTH   = 6,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        APB_ADDR_WIDTH = 12,
  parameter logic [AXI_ADDR_WIDTH-1:0] AXI_BASE_ADDR  = 32'h1A10_0000,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID         = '0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [APB_ADDR_WIDTH-1:0]   paddr,
  input  logic [31:0]                 pwdata,
  output logic [31:0]                 prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic [AXI_ID_WIDTH-1:0]     AWID,
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WLAST,
  output logic                        WVALID,
  input  logic                        WREADY,
  input  logic [AXI_ID_WIDTH-1:0]     BID,
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  output logic [AXI_ID_WIDTH-1:0]     ARID,
  output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]                  ARLEN,
  output logic [2:0]                  ARSIZE,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]     RID,
  input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RLAST,
  input  logic                        RVALID,
  output logic                        RREADY
);
  localparam int NL = AXI_DATA_WIDTH / 32;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;
  localparam int SW = AXI_DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t                    r_state, w_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_wdata, r_prdata;
  logic                      r_aw_done, r_w_done, r_pready, r_pslverr;
  logic [LW-1:0]             w_lane;
  logic                      w_setup, w_aw_ok, w_w_ok, w_b_hs, w_r_hs, w_unused;
  assign w_setup  = r_state == IDLE && psel && !penable;
  assign w_aw_ok  = r_aw_done | AWREADY;
  assign w_w_ok   = r_w_done | WREADY;
  assign w_b_hs   = r_state == WR_RESP && BVALID;
  assign w_r_hs   = r_state == RD_RESP && RVALID;
  assign w_lane   = (NL > 1) ? r_addr[2 +: LW] : '0;
  assign w_unused = ^{BID, RID, RLAST, BRESP[0], RRESP[0]};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_setup ? (pwrite ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ:  w_next = (w_aw_ok && w_w_ok) ? WR_RESP : WR_REQ;
      WR_RESP: w_next = BVALID ? DONE : WR_RESP;
      RD_REQ:  w_next = ARREADY ? RD_RESP : RD_REQ;
      RD_RESP: w_next = RVALID ? DONE : RD_RESP;
      default: w_next = IDLE;
    endcase
  end
  // each write channel valid drops on its own handshake while the other may still wait
  always_comb begin
    AWVALID = r_state == WR_REQ && !r_aw_done;
    WVALID  = r_state == WR_REQ && !r_w_done;
    BREADY  = r_state == WR_RESP;
    ARVALID = r_state == RD_REQ;
    RREADY  = r_state == RD_RESP;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      if (w_setup) begin
        r_addr  <= (AXI_BASE_ADDR | AXI_ADDR_WIDTH'(paddr)) & ~AXI_ADDR_WIDTH'(2'b11);
        r_wdata <= pwdata;
      end
      r_aw_done <= r_state == WR_REQ && w_aw_ok;
      r_w_done  <= r_state == WR_REQ && w_w_ok;
      r_pready  <= w_b_hs || w_r_hs;
      r_pslverr <= w_b_hs ? BRESP[1] : w_r_hs ? RRESP[1] : 1'b0;
      if (w_r_hs) r_prdata <= RDATA[32*w_lane +: 32];
    end
  assign AWID    = AXI_ID;
  assign AWADDR  = r_addr;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign WDATA   = {NL{r_wdata}};
  assign WSTRB   = SW'(4'hF) << (4*w_lane);
  assign WLAST   = 1'b1;
  assign ARID    = AXI_ID;
  assign ARADDR  = r_addr;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = 3'b010;
  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;
endmodule

// File: tb/tb_apb2axi.sv
// tb_apb2axi: directed APB transfers against a configurable AXI slave model; expectations are
// queued at issue time and popped by the AXI-slave monitor and the APB-completion monitor.
module tb_apb2axi;
  logic        clk = 1'b0, rstn;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [5:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  apb2axi dut (
    .clk(clk), .rstn(rstn), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  typedef struct {logic [31:0] addr; int hold;} aw_t;
  typedef struct {logic [63:0] data; logic [7:0] strb; int hold;} w_t;
  typedef struct {logic [31:0] prd; logic err; int lat; int setup;} apb_t;
  aw_t         exp_aw[$];
  w_t          exp_w[$];
  logic [31:0] exp_ar[$];
  apb_t        exp_apb[$];
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [63:0] cfg_rdata = '0;
  // AXI slave model plus channel monitor
  initial begin
    int  aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    bit  aw_hs, w_hs;
    aw_t ea;
    w_t  ew;
    logic [31:0] er;
    {AWREADY, WREADY, ARREADY, BVALID, RVALID} = '0;
    BRESP = 2'b00; RRESP = 2'b00; RDATA = '0; BID = '0; RID = '0; RLAST = 1'b1;
    {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
    aw_hs = 0; w_hs = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        {AWREADY, WREADY, ARREADY, BVALID, RVALID} = '0;
        {aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt} = '0;
        aw_hs = 0; w_hs = 0;
      end else begin
        AWREADY = AWVALID && aw_cnt >= aw_dly;
        WREADY  = WVALID && w_cnt >= w_dly;
        ARREADY = ARVALID && ar_cnt >= ar_dly;
        BVALID  = BREADY && b_cnt >= b_dly;
        BRESP   = cfg_bresp;
        RVALID  = RREADY && r_cnt >= r_dly;
        RDATA   = cfg_rdata;
        RRESP   = cfg_rresp;
        if (w_hs && !aw_hs) chk("wvalid_dropped", WVALID, 0);
        if (aw_hs && !w_hs) chk("awvalid_dropped", AWVALID, 0);
        if (BREADY && b_cnt == 0) chk("bready_after_both_hs", aw_hs && w_hs, 1);
        if (AWVALID && AWREADY) begin
          if (exp_aw.size() == 0) fail_now("unexpected_aw");
          else begin
            ea = exp_aw.pop_front();
            chk("awaddr", AWADDR, ea.addr);
            chk("aw_len_size_id", {AWLEN, AWSIZE, AWID}, {8'd0, 3'b010, 6'd0});
            chk("awvalid_hold", aw_cnt + 1, ea.hold);
          end
          aw_hs = 1;
        end
        if (WVALID && WREADY) begin
          if (exp_w.size() == 0) fail_now("unexpected_w");
          else begin
            ew = exp_w.pop_front();
            chk("wdata", WDATA, ew.data);
            chk("wstrb_wlast", {WSTRB, WLAST}, {ew.strb, 1'b1});
            chk("wvalid_hold", w_cnt + 1, ew.hold);
          end
          w_hs = 1;
        end
        if (ARVALID && ARREADY) begin
          if (exp_ar.size() == 0) fail_now("unexpected_ar");
          else begin
            er = exp_ar.pop_front();
            chk("araddr", ARADDR, er);
            chk("ar_len_size_id", {ARLEN, ARSIZE, ARID}, {8'd0, 3'b010, 6'd0});
          end
        end
        if (BVALID) begin aw_hs = 0; w_hs = 0; end
        aw_cnt = (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
        w_cnt  = (WVALID && !WREADY) ? w_cnt + 1 : 0;
        ar_cnt = (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
        b_cnt  = (BREADY && !BVALID) ? b_cnt + 1 : 0;
        r_cnt  = (RREADY && !RVALID) ? r_cnt + 1 : 0;
      end
    end
  end
  // APB completion monitor
  initial begin
    bit   prev_rdy = 0;
    apb_t e;
    forever begin
      @(posedge clk); #1;
      if (prev_rdy) chk("pready_one_cycle", pready, 0);
      if (pready) begin
        if (exp_apb.size() == 0) fail_now("unexpected_pready");
        else begin
          e = exp_apb.pop_front();
          chk("latency_incl_setup", cyc - e.setup + 1, e.lat);
          chk("pslverr", pslverr, e.err);
          chk("prdata", prdata, e.prd);
        end
      end
      prev_rdy = pready;
    end
  end
  task automatic exp_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input int awh, input int wh);
    exp_aw.push_back('{a, awh});
    exp_w.push_back('{d, s, wh});
  endtask
  // called aligned to #1 after a rising edge; returns aligned the same way, one cycle after pready
  task automatic apb_xfer(input bit wr, input logic [11:0] a, input logic [31:0] d,
                          input logic [31:0] prd, input bit err, input int lat);
    int n;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
    exp_apb.push_back('{prd, err, lat, cyc});
    @(posedge clk); #1;
    penable = 1;
    n = 0;
    while (!pready && n < 50) begin @(posedge clk); #1; n++; end
    if (!pready) fail_now("pready_timeout");
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valids"}, {AWVALID, WVALID, ARVALID}, 3'b000);
    chk({tag, "_readys"}, {BREADY, RREADY}, 2'b00);
    chk({tag, "_pready_pslverr"}, {pready, pslverr}, 2'b00);
    chk({tag, "_prdata"}, prdata, 32'h0);
  endtask
  initial begin
    int n;
    rstn = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    @(negedge clk) rstn = 1;
    @(posedge clk); #1;
    // zero-wait write to lane 1
    exp_write(32'h1A10_0004, 64'hDEADBEEF_DEADBEEF, 8'hF0, 1, 1);
    apb_xfer(1, 12'h004, 32'hDEADBEEF, 32'h0, 0, 4);
    // zero-wait read from lane 0
    cfg_rdata = 64'h11111111_22222222;
    exp_ar.push_back(32'h1A10_0008);
    apb_xfer(0, 12'h008, 32'h0, 32'h22222222, 0, 4);
    // AWREADY late, WREADY immediate
    aw_dly = 2;
    exp_write(32'h1A10_0010, 64'h12345678_12345678, 8'h0F, 3, 1);
    apb_xfer(1, 12'h010, 32'h12345678, 32'h22222222, 0, 6);
    aw_dly = 0;
    // SLVERR read, then OKAY write
    cfg_rdata = 64'hCAFEF00D_0BADBEEF; cfg_rresp = 2'b10;
    exp_ar.push_back(32'h1A10_000C);
    apb_xfer(0, 12'h00C, 32'h0, 32'hCAFEF00D, 1, 4);
    exp_write(32'h1A10_0020, 64'hA5A5A5A5_A5A5A5A5, 8'h0F, 1, 1);
    apb_xfer(1, 12'h020, 32'hA5A5A5A5, 32'hCAFEF00D, 0, 4);
    // back-to-back: unaligned DECERR write, EXOKAY read at top of APB space, OKAY write
    cfg_bresp = 2'b11; cfg_rresp = 2'b01; cfg_rdata = 64'h55555555_66666666;
    exp_write(32'h1A10_0004, 64'h01020304_01020304, 8'hF0, 1, 1);
    apb_xfer(1, 12'h007, 32'h01020304, 32'hCAFEF00D, 1, 4);
    exp_ar.push_back(32'h1A10_0FFC);
    apb_xfer(0, 12'hFFF, 32'h0, 32'h55555555, 0, 4);
    cfg_bresp = 2'b00;
    exp_write(32'h1A10_0100, 64'h0, 8'h0F, 1, 1);
    apb_xfer(1, 12'h100, 32'h0, 32'h55555555, 0, 4);
    // reset while waiting for BVALID
    b_dly = 20;
    exp_write(32'h1A10_0030, 64'h00000077_00000077, 8'h0F, 1, 1);
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h030; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1;
    n = 0;
    while (!BREADY && n < 20) begin @(posedge clk); #1; n++; end
    if (!BREADY) fail_now("bready_timeout");
    repeat (2) @(posedge clk);
    #1 rstn = 0; psel = 0; penable = 0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk) rstn = 1;
    b_dly = 0;
    @(posedge clk); #1;
    exp_write(32'h1A10_0040, 64'h89ABCDEF_89ABCDEF, 8'h0F, 1, 1);
    apb_xfer(1, 12'h040, 32'h89ABCDEF, 32'h0, 0, 4);
    cfg_rdata = 64'h99998888_77776666; cfg_rresp = 2'b00;
    exp_ar.push_back(32'h1A10_0044);
    apb_xfer(0, 12'h044, 32'h0, 32'h99998888, 0, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("leftover_apb", exp_apb.size(), 0);
    chk("leftover_aw_w", exp_aw.size() + exp_w.size(), 0);
    chk("leftover_ar", exp_ar.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
